// File: rtl/hash_cracker_pkg.sv
// Shared types for the hash-cracker datapath: candidate width/type and the
// dispatcher FSM state encoding.
package hash_cracker_pkg;

    // Password candidate width as produced by the generator / FIFO.
    localparam int unsigned CAND_W = 56;

    typedef logic [CAND_W-1:0] candidate_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        OFFER
    } dispatch_state_t;

endpackage

// File: rtl/candidate_dispatcher_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// above ptr, wrapping modulo NUM_CORES. When nothing is requested the grant
// falls back to ptr and any is low.
module rr_pick #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     grant,
    output logic                 any
);

    // Linear scan from ptr upward; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = ptr;
        any   = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/candidate_dispatcher.sv
// Candidate dispatcher: sole reader of the candidate FIFO. Fetches one
// candidate at a time and offers it to a single hash core chosen round-robin
// among the ready cores. All outputs are registered.
// Optional build macro CANDIDATE_DISPATCHER_CORE_MASK_EN adds a core_mask
// input that removes masked cores from eligibility.
module candidate_dispatcher
    import hash_cracker_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DATA_W    = CAND_W,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_W-1:0]    fifo_data,
    output logic                 fifo_read,
    input  logic [NUM_CORES-1:0] core_ready,
`ifdef CANDIDATE_DISPATCHER_CORE_MASK_EN
    input  logic [NUM_CORES-1:0] core_mask,
`endif
    output logic [NUM_CORES-1:0] core_valid,
    output logic [DATA_W-1:0]    core_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     dispatched
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

    dispatch_state_t      state;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     grant_q;
    logic [NUM_CORES-1:0] eligible;
    logic [IDX_W-1:0]     pick_grant;
    logic                 pick_any;
    logic                 transfer;
    logic [IDX_W-1:0]     ptr_next;

`ifdef CANDIDATE_DISPATCHER_CORE_MASK_EN
    // Masked cores are ineligible for new grants; an existing offer is not
    // affected because transfer uses the raw ready.
    assign eligible = core_ready & ~core_mask;
`else
    assign eligible = core_ready;
`endif

    rr_pick #(
        .NUM_CORES(NUM_CORES),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req  (eligible),
        .ptr  (ptr_q),
        .grant(pick_grant),
        .any  (pick_any)
    );

    // Handshake on the granted core only; the grant never moves once offered.
    assign transfer = core_valid[grant_q] & core_ready[grant_q];

    // Priority restarts just past the core that was served; constant 0 for one core.
    assign ptr_next = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

    // Dispatch FSM with registered outputs, pointer and hold register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fifo_read  <= 1'b0;
            core_valid <= '0;
            core_data  <= '0;
            busy       <= 1'b0;
            dispatched <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // fifo_empty is only looked at here, so the FIFO is never
                    // strobed while empty.
                    if (enable && !fifo_empty && pick_any) begin
                        state     <= FETCH;
                        fifo_read <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    fifo_read <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    // FIFO read data is valid now, one cycle after the strobe.
                    core_data  <= fifo_data;
                    grant_q    <= pick_grant;
                    core_valid <= ONE_HOT0 << pick_grant;
                    state      <= OFFER;
                end
                OFFER: begin
                    // Wait indefinitely for the granted core.
                    if (transfer) begin
                        core_valid <= '0;
                        dispatched <= dispatched + CNT_W'(1);
                        ptr_q      <= ptr_next;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_dispatcher.sv
// Directed self-checking bench for candidate_dispatcher (4 cores).
module tb_candidate_dispatcher;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [55:0] fifo_data = '0;
    logic        fifo_read;
    logic [3:0]  core_ready = 4'b0;
    logic [3:0]  core_valid;
    logic [55:0] core_data;
    logic        busy;
    logic [31:0] dispatched;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    candidate_dispatcher #(
        .NUM_CORES(4),
        .DATA_W   (56),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_read (fifo_read),
        .core_ready(core_ready),
`ifdef CANDIDATE_DISPATCHER_CORE_MASK_EN
        .core_mask (4'b0000),
`endif
        .core_valid(core_valid),
        .core_data (core_data),
        .busy      (busy),
        .dispatched(dispatched)
    );

    // FIFO model: registered read data, valid the cycle after the strobe.
    logic [55:0] mem [0:31];
    int wr = 0;
    int rd = 0;
    int underflow = 0;
    assign fifo_empty = (rd == wr);

    always @(posedge clk) begin
        if (fifo_read) begin
            if (rd == wr) underflow <= underflow + 1;
            fifo_data <= mem[rd[4:0]];
            rd <= rd + 1;
        end
    end

    // Monitor on the falling edge: these are the values the next rising edge sees.
    int cyc = 0;
    int reads = 0;
    int busy_cnt = 0;
    int vcnt [0:3];
    int n_log = 0;
    int log_core [0:63];
    logic [55:0] log_data [0:63];
    int log_cyc [0:63];

    initial for (int i = 0; i < 4; i++) vcnt[i] = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read) reads <= reads + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        for (int i = 0; i < 4; i++) if (core_valid[i]) vcnt[i] <= vcnt[i] + 1;
        if (reset_n && |(core_valid & core_ready)) begin
            for (int i = 0; i < 4; i++) begin
                if (core_valid[i] && core_ready[i]) log_core[n_log] <= i;
            end
            log_data[n_log] <= core_data;
            log_cyc[n_log]  <= cyc;
            n_log <= n_log + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [55:0] v);
        mem[wr[4:0]] = v;
        wr = wr + 1;
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_log < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(n_log >= target), 64'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k;
        k = 0;
        while (core_valid == 4'b0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(core_valid != 4'b0), 64'd1);
    endtask

    initial begin
        int n0, r0, b0, k;
        logic [31:0] d0;
        int v0 [0:3];

        // Reset state
        tick();
        tick();
        check("rst_fifo_read", 64'(fifo_read), 64'd0);
        check("rst_core_valid", 64'(core_valid), 64'd0);
        check("rst_core_data", 64'(core_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dispatched", 64'(dispatched), 64'd0);
        reset_n = 1'b1;
        tick();

        // 1: four candidates to cores 0..3 in order, 4 cycles apart
        for (int i = 1; i <= 4; i++) push(56'(i));
        core_ready = 4'b1111;
        enable = 1'b1;
        wait_log(4, 40, "t1_wait");
        for (int i = 0; i < 4; i++) begin
            check("t1_core", 64'(log_core[i]), 64'(i));
            check("t1_data", 64'(log_data[i]), 64'(i + 1));
        end
        for (int i = 1; i < 4; i++) check("t1_gap", 64'(log_cyc[i] - log_cyc[i-1]), 64'd4);
        check("t1_dispatched", 64'(dispatched), 64'd4);
        check("t1_reads", 64'(reads), 64'd4);

        // 2: empty FIFO, nothing happens for 100 cycles
        r0 = reads;
        b0 = busy_cnt;
        for (int i = 0; i < 100; i++) tick();
        check("t2_reads", 64'(reads), 64'(r0));
        check("t2_busy_cnt", 64'(busy_cnt), 64'(b0));
        check("t2_busy", 64'(busy), 64'd0);
        check("t2_dispatched", 64'(dispatched), 64'd4);

        // 3: only core 2 ready, three candidates all go to core 2
        for (int i = 0; i < 4; i++) v0[i] = vcnt[i];
        n0 = n_log;
        core_ready = 4'b0100;
        push(56'h5); push(56'h6); push(56'h7);
        wait_log(n0 + 3, 60, "t3_wait");
        for (int i = 0; i < 3; i++) begin
            check("t3_core", 64'(log_core[n0+i]), 64'd2);
            check("t3_data", 64'(log_data[n0+i]), 64'(5 + i));
        end
        check("t3_v0", 64'(vcnt[0]), 64'(v0[0]));
        check("t3_v1", 64'(vcnt[1]), 64'(v0[1]));
        check("t3_v3", 64'(vcnt[3]), 64'(v0[3]));
        check("t3_v2", 64'(vcnt[2] - v0[2]), 64'd3);
        // Pointer now 3: with all cores ready the next goes to core 3
        core_ready = 4'b1111;
        push(56'h8);
        wait_log(n0 + 4, 20, "t3_ptr_wait");
        check("t3_ptr_core", 64'(log_core[n0+3]), 64'd3);
        check("t3_ptr_data", 64'(log_data[n0+3]), 64'h8);

        // 4: core 1 granted, ready held low 10 cycles in OFFER
        for (int i = 0; i < 4; i++) v0[i] = vcnt[i];
        n0 = n_log;
        d0 = dispatched;
        core_ready = 4'b0010;
        push(56'h00_1234_5678_9abc);
        wait_valid(20, "t4_wait");
        core_ready = 4'b0000;
        check("t4_offer", 64'(core_valid), 64'b0010);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 64'(core_valid), 64'b0010);
            check("t4_hold_data", 64'(core_data), 64'h00_1234_5678_9abc);
        end
        check("t4_no_xfer", 64'(dispatched), 64'(d0));
        core_ready = 4'b0010;
        tick();
        check("t4_valid_drop", 64'(core_valid), 64'd0);
        check("t4_dispatched", 64'(dispatched), 64'(d0 + 1));
        check("t4_log_n", 64'(n_log), 64'(n0 + 1));
        check("t4_log_core", 64'(log_core[n0]), 64'd1);
        check("t4_log_data", 64'(log_data[n0]), 64'h00_1234_5678_9abc);
        check("t4_other_cores", 64'(vcnt[0] + vcnt[2] + vcnt[3]), 64'(v0[0] + v0[2] + v0[3]));

        // 5: enable dropped the cycle after FETCH; candidate still delivered
        n0 = n_log;
        d0 = dispatched;
        r0 = reads;
        core_ready = 4'b1111;
        push(56'hA); push(56'hB);
        k = 0;
        while (!fifo_read && k < 20) begin
            tick();
            k++;
        end
        check("t5_fetch_wait", 64'(fifo_read), 64'd1);
        tick();
        enable = 1'b0;
        wait_log(n0 + 1, 20, "t5_wait");
        for (int i = 0; i < 20; i++) tick();
        check("t5_core", 64'(log_core[n0]), 64'd2);
        check("t5_data", 64'(log_data[n0]), 64'hA);
        check("t5_dispatched", 64'(dispatched), 64'(d0 + 1));
        check("t5_reads", 64'(reads), 64'(r0 + 1));
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_fifo_nonempty", 64'(fifo_empty), 64'd0);

        // 6: asynchronous reset mid-OFFER
        core_ready = 4'b1000;
        enable = 1'b1;
        wait_valid(20, "t6_wait");
        core_ready = 4'b0000;
        check("t6_offer", 64'(core_valid), 64'b1000);
        check("t6_offer_data", 64'(core_data), 64'hB);
        n0 = n_log;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(core_valid), 64'd0);
        check("t6_rst_data", 64'(core_data), 64'd0);
        check("t6_rst_read", 64'(fifo_read), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_dispatched", 64'(dispatched), 64'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("t6_lost", 64'(n_log), 64'(n0));
        push(56'hC);
        core_ready = 4'b1111;
        wait_log(n0 + 1, 20, "t6_after_wait");
        check("t6_after_core", 64'(log_core[n0]), 64'd0);
        check("t6_after_data", 64'(log_data[n0]), 64'hC);
        check("t6_after_dispatched", 64'(dispatched), 64'd1);

        check("fifo_underflow", 64'(underflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
